// File: rtl/adj_pkg.sv
// Shared types and default constants for the adjust-button stepper.
package adj_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        PULSE  = 2'd2,
        REPEAT = 2'd3
    } adj_state_e;

    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_CNT_W      = 21;
    localparam int DEF_SHORT_MAX  = 7;
    localparam int DEF_LONG_MIN   = 1024;
    localparam int DEF_REPEAT_PER = 256;
    localparam int DEF_PULSE_LEN  = 4;

endpackage

// File: rtl/adj_pulse_gen.sv
// One-hot step stretcher: a start strobe launches a PULSE_LEN-cycle pulse on
// the chosen channel; 'last' flags the final cycle of the pulse.
module adj_pulse_gen
    import adj_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int PULSE_LEN = DEF_PULSE_LEN,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_adj,
    input  logic              reset,
    input  logic              start,
    input  logic [CH_W-1:0]   ch,
    output logic [NUM_CH-1:0] step,
    output logic              busy,
    output logic              last
);

    localparam logic [3:0] REM_INIT = 4'(PULSE_LEN - 1);

    logic [3:0] rem;

    always_ff @(negedge clk_adj) begin
        if (!reset) begin
            step <= '0;
            rem  <= '0;
        end else if (start) begin
            step <= NUM_CH'(1) << ch;
            rem  <= REM_INIT;
        end else if (rem != 4'd0) begin
            rem <= rem - 4'd1;
        end else begin
            step <= '0;
        end
    end

    assign busy = |step;
    assign last = busy && (rem == 4'd0);

endmodule

// File: rtl/adjust_stepper.sv
// Button-driven channel stepper: short press gives one step pulse on the
// selected channel; ADJ_AUTOREPEAT_EN adds hold-to-repeat stepping.
module adjust_stepper
    import adj_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int SHORT_MAX  = DEF_SHORT_MAX,
    parameter int LONG_MIN   = DEF_LONG_MIN,
    parameter int REPEAT_PER = DEF_REPEAT_PER,
    parameter int PULSE_LEN  = DEF_PULSE_LEN,
    localparam int SEL_W     = $clog2(NUM_CH + 1)
) (
    input  logic              clk_adj,
    input  logic              reset,
    input  logic              ADJ,
    input  logic [SEL_W-1:0]  adj_sel,
    output logic [NUM_CH-1:0] step,
    output logic [NUM_CH-1:0] led,
    output logic              busy
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam longint CNT_LIM = (longint'(1) << CNT_W) - 1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] SHORT_C = CNT_W'(SHORT_MAX);

    if (NUM_CH < 1 || NUM_CH > 8 || PULSE_LEN < 1 || PULSE_LEN > 16 ||
        LONG_MIN <= SHORT_MAX || SHORT_MAX > CNT_LIM || LONG_MIN > CNT_LIM ||
        REPEAT_PER > CNT_LIM || REPEAT_PER < 1) begin : g_bad_params
        $error("adjust_stepper: illegal parameter set");
    end

    // state is the debug view of the controller for checkers and benches.
    adj_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic [CH_W-1:0] ch_q;
    logic            start_q;
    logic            hold;
    logic            sel_ok;
    logic [CH_W-1:0] sel_ch;
    logic            pulse_last;

    assign sel_ok = (adj_sel != '0) && (adj_sel <= SEL_W'(NUM_CH));
    assign sel_ch = CH_W'(adj_sel - SEL_W'(1));

`ifdef ADJ_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_MIN - 1);
    localparam logic [CNT_W-1:0] RPT_C   = CNT_W'(REPEAT_PER);
    logic [CNT_W-1:0] rpt_tmr;
    logic             rep;
`endif

    // Handshake-free control: start_q is a one-cycle strobe into the pulse
    // generator, and pulse_last tells the FSM the pulse is in its final cycle.
    always_ff @(negedge clk_adj) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            ch_q    <= '0;
            start_q <= 1'b0;
            hold    <= 1'b0;
`ifdef ADJ_AUTOREPEAT_EN
            rpt_tmr <= '0;
            rep     <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            // A press held across the end of a pulse must be released first.
            if (state == PULSE) hold <= ADJ;
            else if (!ADJ)      hold <= 1'b0;
`ifdef ADJ_AUTOREPEAT_EN
            if (rep) rpt_tmr <= (rpt_tmr == RPT_C) ? CNT_W'(1) : rpt_tmr + CNT_W'(1);
`endif
            case (state)
                IDLE: begin
                    if (ADJ && !hold) begin
                        state <= PRESS;
                        cnt   <= CNT_W'(1);
                    end
                end
                PRESS: begin
                    if (ADJ) begin
                        if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
`ifdef ADJ_AUTOREPEAT_EN
                        if (cnt == LONG_M1 && sel_ok) begin
                            ch_q    <= sel_ch;
                            start_q <= 1'b1;
                            rep     <= 1'b1;
                            rpt_tmr <= CNT_W'(1);
                            cnt     <= '0;
                            state   <= PULSE;
                        end
`endif
                    end else begin
                        cnt <= '0;
                        if (cnt < SHORT_C && sel_ok) begin
                            ch_q    <= sel_ch;
                            start_q <= 1'b1;
                            state   <= PULSE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                PULSE: begin
`ifdef ADJ_AUTOREPEAT_EN
                    if (!ADJ) rep <= 1'b0;
                    if (pulse_last) state <= (rep && ADJ) ? REPEAT : IDLE;
`else
                    if (pulse_last) state <= IDLE;
`endif
                end
`ifdef ADJ_AUTOREPEAT_EN
                REPEAT: begin
                    if (!ADJ) begin
                        rep   <= 1'b0;
                        state <= IDLE;
                    end else if (rpt_tmr == RPT_C && sel_ok) begin
                        ch_q    <= sel_ch;
                        start_q <= 1'b1;
                        state   <= PULSE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    adj_pulse_gen #(
        .NUM_CH    (NUM_CH),
        .PULSE_LEN (PULSE_LEN)
    ) u_pulse_gen (
        .clk_adj (clk_adj),
        .reset   (reset),
        .start   (start_q),
        .ch      (ch_q),
        .step    (step),
        .busy    (busy),
        .last    (pulse_last)
    );

    assign led = step;

endmodule
